// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: multi-channel seven-segment display controller.
// Snapshots CHANNELS binary values, converts them one at a time with a
// bit-serial double-dabble engine, and commits all channel digits at once.
module seg_display_ctrl #(
  parameter int CHANNELS = 2,
  parameter int IN_WIDTH = 6,
  parameter int DIGITS   = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           mode,
  input  logic                           blank_lz,
  input  logic [CHANNELS*IN_WIDTH-1:0]   in,
  output logic [CHANNELS*DIGITS*7-1:0]   hex,
  output logic [CHANNELS-1:0]            overflow,
  output logic                           valid
);

  // Digit register is wide enough that the conversion never truncates.
  localparam int BCD_MIN = 4 * ((IN_WIDTH + 2) / 3) + 4;
  localparam int BW      = (4 * DIGITS > BCD_MIN) ? 4 * DIGITS : BCD_MIN;
  localparam int NN      = BW / 4;
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BCW     = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int SW      = CHANNELS * IN_WIDTH;
  localparam int HW      = CHANNELS * DIGITS * 7;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {ST_CAPTURE, ST_CONVERT, ST_COMMIT} state_e;

  state_e              state_q;
  logic [SW-1:0]       snap_q;
  logic                mode_q;
  logic                blank_q;
  logic [CW-1:0]       ch_q;
  logic [BCW-1:0]      bit_q;
  logic [BW-1:0]       bcd_q;
  logic [HW-1:0]       hex_q;
  logic [CHANNELS-1:0] ovf_q;
  logic                valid_q;

  logic [BW-1:0]       bcd_corr_d;
  logic [BW-1:0]       bcd_shift_d;
  logic [DIGITS*7-1:0] seg_word_d;
  logic                ovf_now_d;
  logic                last_bit;
  logic [HW-1:0]       stage_hex;
  logic [CHANNELS-1:0] stage_ovf;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // The snapshot is one shift register; its MSB is always the next bit in.
  // Channels are therefore converted from the highest index down.
  assign last_bit = (bit_q == BCW'(IN_WIDTH - 1));

  // Add-3 correction (decimal only) followed by a one-bit left shift.
  always_comb begin
    bcd_corr_d = bcd_q;
    if (!mode_q) begin
      for (int n = 0; n < NN; n++) begin
        if (bcd_q[4*n +: 4] >= 4'd5) begin
          bcd_corr_d[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
        end
      end
    end
    bcd_shift_d = (bcd_corr_d << 1) | BW'(snap_q[SW-1]);
  end

  // Map the finished digits to segments with overflow and zero blanking.
  always_comb begin
    logic       lead;
    logic [3:0] nib;
    ovf_now_d  = 1'b0;
    seg_word_d = '0;
    lead       = blank_q;
    nib        = 4'd0;
    for (int n = DIGITS; n < NN; n++) begin
      ovf_now_d = ovf_now_d | (bcd_shift_d[4*n +: 4] != 4'd0);
    end
    for (int d = DIGITS - 1; d >= 0; d--) begin
      nib = bcd_shift_d[4*d +: 4];
      if (ovf_now_d) begin
        seg_word_d[7*d +: 7] = SEG_DASH;
      end else if (lead && (d != 0) && (nib == 4'd0)) begin
        seg_word_d[7*d +: 7] = SEG_BLANK;
      end else begin
        seg_word_d[7*d +: 7] = seg7(nib);
        lead = 1'b0;
      end
    end
  end

  // Per-channel staging area, written when that channel's last bit shifts in.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_stage
    logic [DIGITS*7-1:0] seg_q;
    logic                ovf_q;

    // Hold this channel's result until the commit copies it out.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        seg_q <= '1;
        ovf_q <= 1'b0;
      end else if (state_q == ST_CONVERT && last_bit &&
                   ch_q == CW'(CHANNELS - 1 - gi)) begin
        seg_q <= seg_word_d;
        ovf_q <= ovf_now_d;
      end
    end

    assign stage_hex[gi*DIGITS*7 +: DIGITS*7] = seg_q;
    assign stage_ovf[gi]                      = ovf_q;
  end

  // Capture / convert / commit sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CAPTURE;
      snap_q  <= '0;
      mode_q  <= 1'b0;
      blank_q <= 1'b0;
      ch_q    <= '0;
      bit_q   <= '0;
      bcd_q   <= '0;
      hex_q   <= '1;
      ovf_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        ST_CAPTURE: begin
          if (en) begin
            snap_q  <= in;
            mode_q  <= mode;
            blank_q <= blank_lz;
            ch_q    <= '0;
            bit_q   <= '0;
            bcd_q   <= '0;
            state_q <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          snap_q <= snap_q << 1;
          if (last_bit) begin
            bit_q <= '0;
            bcd_q <= '0;
            if (ch_q == CW'(CHANNELS - 1)) begin
              state_q <= ST_COMMIT;
            end else begin
              ch_q <= ch_q + CW'(1);
            end
          end else begin
            bit_q <= bit_q + BCW'(1);
            bcd_q <= bcd_shift_d;
          end
        end
        ST_COMMIT: begin
          hex_q   <= stage_hex;
          ovf_q   <= stage_ovf;
          valid_q <= 1'b1;
          state_q <= ST_CAPTURE;
        end
        default: state_q <= ST_CAPTURE;
      endcase
    end
  end

  assign hex      = hex_q;
  assign overflow = ovf_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: directed vectors for the default instance and an
// 8-bit-input instance, with hand-computed segment patterns.
module tb_seg_display_ctrl;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
  localparam logic [6:0] S4 = 7'h19, S5 = 7'h12, S6 = 7'h02, S7 = 7'h78;
  localparam logic [6:0] S9 = 7'h10, SF = 7'h0E, SBL = 7'h7F, SDA = 7'h3F;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        en, mode, blank;
  logic [11:0] in_v;
  logic [27:0] hex_v;
  logic [1:0]  ovf_v;
  logic        valid_v;

  logic        en8, mode8, blank8;
  logic [15:0] in8;
  logic [27:0] hex8;
  logic [1:0]  ovf8;
  logic        valid8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seg_display_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .blank_lz(blank),
    .in(in_v), .hex(hex_v), .overflow(ovf_v), .valid(valid_v)
  );

  seg_display_ctrl #(.CHANNELS(2), .IN_WIDTH(8), .DIGITS(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .mode(mode8), .blank_lz(blank8),
    .in(in8), .hex(hex8), .overflow(ovf8), .valid(valid8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [27:0] hx(input logic [6:0] c1t, input logic [6:0] c1o,
                                      input logic [6:0] c0t, input logic [6:0] c0o);
    return {c1t, c1o, c0t, c0o};
  endfunction

  // Count rising edges until valid is seen; returns limit+1 on timeout.
  task automatic wait_valid(input bit use8, input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(use8 ? valid8 : valid_v) && n <= limit);
  endtask

  task automatic count_valid(input bit use8, input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (use8 ? valid8 : valid_v) cnt++;
    end
  endtask

  task automatic txn(input string what, input int lat);
    $display("txn %-14s latency=%0d hex=%07h ovf=%b hex8=%07h ovf8=%b",
             what, lat, hex_v, ovf_v, hex8, ovf8);
  endtask

  initial begin
    int n, c;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; blank = 1'b0; in_v = '0;
    en8 = 1'b0; mode8 = 1'b0; blank8 = 1'b0; in8 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_hex", 32'(hex_v), 32'hFFFFFFF);
    check("rst_ovf", 32'(ovf_v), 32'h0);
    check("rst_valid", 32'(valid_v), 32'h0);
    check("rst_hex8", 32'(hex8), 32'hFFFFFFF);
    @(negedge clk) rst_n = 1'b1;
    count_valid(0, 20, c);
    check("idle_no_valid", 32'(c), 32'h0);
    check("idle_hex", 32'(hex_v), 32'hFFFFFFF);
    txn("reset", 0);

    // Decimal, no blanking: ch0=37, ch1=5
    @(negedge clk);
    in_v = {6'd5, 6'd37}; en = 1'b1;
    @(posedge clk);
    wait_valid(0, 40, n);
    check("dec_latency", 32'(n), 32'd13);
    check("dec_hex", 32'(hex_v), 32'(hx(S0, S5, S3, S7)));
    check("dec_ovf", 32'(ovf_v), 32'h0);
    txn("dec 37/5", n);
    @(posedge clk); #1;
    check("valid_width", 32'(valid_v), 32'h0);
    wait_valid(0, 40, n);
    check("refresh_period", 32'(n + 1), 32'd14);

    // Blanking
    blank = 1'b1; in_v = {6'd5, 6'd0};
    wait_valid(0, 40, n);
    check("blank_period", 32'(n), 32'd14);
    check("blank_hex_0_5", 32'(hex_v), 32'(hx(SBL, S5, SBL, S0)));
    txn("blank 0/5", n);
    in_v = {6'd63, 6'd40};
    wait_valid(0, 40, n);
    check("blank_hex_40_63", 32'(hex_v), 32'(hx(S6, S3, S4, S0)));
    txn("blank 40/63", n);

    // Snapshot: input changes in the 3rd CONVERT cycle
    blank = 1'b0; in_v = {6'd5, 6'd37};
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    in_v = {6'd5, 6'd12};
    wait_valid(0, 40, n);
    check("snap_latency", 32'(n), 32'd11);
    check("snap_old", 32'(hex_v), 32'(hx(S0, S5, S3, S7)));
    txn("snap 37", n);
    wait_valid(0, 40, n);
    check("snap_new", 32'(hex_v), 32'(hx(S0, S5, S1, S2)));
    txn("snap 12", n);

    // Enable dropped mid-conversion
    in_v = {6'd5, 6'd21};
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    en = 1'b0;
    wait_valid(0, 40, n);
    check("en_drop_latency", 32'(n), 32'd10);
    check("en_drop_hex", 32'(hex_v), 32'(hx(S0, S5, S2, S1)));
    in_v = {6'd5, 6'd37};
    count_valid(0, 40, c);
    check("en_drop_hold", 32'(c), 32'h0);
    check("en_drop_hex_hold", 32'(hex_v), 32'(hx(S0, S5, S2, S1)));
    txn("en drop 21", n);

    // Reset during CONVERT
    @(negedge clk) en = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_hex", 32'(hex_v), 32'hFFFFFFF);
    check("midrst_ovf", 32'(ovf_v), 32'h0);
    check("midrst_valid", 32'(valid_v), 32'h0);
    count_valid(0, 20, c);
    check("midrst_no_valid", 32'(c), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    wait_valid(0, 40, n);
    check("postrst_latency", 32'(n), 32'd13);
    check("postrst_hex", 32'(hex_v), 32'(hx(S0, S5, S3, S7)));
    en = 1'b0;
    txn("post reset", n);

    // 8-bit instance: hex mode and overflow
    @(negedge clk);
    mode8 = 1'b1; blank8 = 1'b0; in8 = {8'd0, 8'h3F}; en8 = 1'b1;
    @(posedge clk);
    wait_valid(1, 60, n);
    check("w8_latency", 32'(n), 32'd17);
    check("w8_hex_3f", 32'(hex8), 32'(hx(S0, S0, S3, SF)));
    check("w8_ovf_3f", 32'(ovf8), 32'h0);
    txn("w8 hex 3F", n);
    mode8 = 1'b0; blank8 = 1'b1; in8 = {8'd99, 8'd150};
    wait_valid(1, 60, n);
    check("w8_period", 32'(n), 32'd18);
    check("w8_hex_150", 32'(hex8), 32'(hx(S9, S9, SDA, SDA)));
    check("w8_ovf_150", 32'(ovf8), 32'h1);
    txn("w8 dec 150/99", n);
    mode8 = 1'b1; blank8 = 1'b1; in8 = {8'h05, 8'hFF};
    wait_valid(1, 60, n);
    check("w8_hex_ff", 32'(hex8), 32'(hx(SBL, S5, SF, SF)));
    check("w8_ovf_ff", 32'(ovf8), 32'h0);
    txn("w8 hex FF/05", n);
    mode8 = 1'b0; blank8 = 1'b0; in8 = {8'd100, 8'd9};
    wait_valid(1, 60, n);
    check("w8_hex_100", 32'(hex8), 32'(hx(SDA, SDA, S0, S9)));
    check("w8_ovf_100", 32'(ovf8), 32'h2);
    txn("w8 dec 9/100", n);
    en8 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_display_ctrl.md
# seg_display_ctrl

Parametrised multi-channel seven-segment display controller for the board-level top. It takes a snapshot of CHANNELS unsigned binary values and converts them one channel at a time with a bit-serial double-dabble engine. The result is shown as decimal or hexadecimal digits, with optional leading-zero blanking and an overflow indication. All channel digits update together, so a display never shows a mix of old and new values.

## Interface
- CHANNELS, 2, number of independent values displayed
- IN_WIDTH, 6, bit width of each input value
- DIGITS, 2, digits per channel
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  high: conversion cycles run; low: the FSM holds in CAPTURE and outputs hold
- mode  input  1  0 = decimal, 1 = hexadecimal; sampled at CAPTURE
- blank_lz  input  1  1 = blank leading zero digits; sampled at CAPTURE
- in  input  CHANNELS*IN_WIDTH  channel c occupies bits [c*IN_WIDTH +: IN_WIDTH]
- hex  output  CHANNELS*DIGITS*7  channel c, digit d at [(c*DIGITS+d)*7 +: 7]; d=0 is the least significant digit
- overflow  output  CHANNELS  per-channel overflow flag, registered at COMMIT
- valid  output  1  one-cycle pulse when hex and overflow update

## Operation
- Segment encoding is active-low, bit order {g,f,e,d,c,b,a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - A=08, b=03, C=46, d=21, E=06, F=0E
  - blank=7F, dash=3F
- FSM states:
  - CAPTURE: if en=1, latch in, mode and blank_lz into snapshot registers, clear channel index and bit counter, go to CONVERT. If en=0, stay.
  - CONVERT: one shift per cycle for IN_WIDTH cycles per channel.
    - Decimal mode: add 3 to every BCD nibble >=5 before each shift.
    - Hex mode: no correction, so nibbles are the binary digits.
    - After the last bit of a channel, store its digits and overflow bit in a staging area. Then advance to the next channel, or go to COMMIT after the last channel.
  - COMMIT: copy the staging area to the hex and overflow output registers, pulse valid, go to CAPTURE.
- The digit register is max(4*DIGITS, 4*ceil(IN_WIDTH/3)+4) bits wide, so the conversion itself never truncates.
- Overflow limits:
  - Decimal: overflow when value >= 10^DIGITS.
  - Hex: overflow when value >= 16^DIGITS; this is impossible when IN_WIDTH <= 4*DIGITS.
  - An overflowing channel shows dash on every digit, and blanking is ignored for it.
- Leading-zero blanking (blank_lz=1): zero digits above the most significant nonzero digit show blank. Digit 0 is always shown, so a value of 0 displays "0".
- Snapshot rule: changes on in, mode or blank_lz after CAPTURE have no effect until the next CAPTURE.
- en going low mid-conversion: the current conversion completes and commits, then the FSM holds in CAPTURE.

## Timing
- Reset values:
  - hex all ones (all segments off)
  - overflow = 0, valid = 0
  - FSM in CAPTURE, all counters and snapshot registers 0
- Refresh period with en=1 is 2 + CHANNELS*IN_WIDTH cycles. Defaults give 14 cycles.
- Latency from the CAPTURE edge to the valid pulse is 1 + CHANNELS*IN_WIDTH cycles. hex and overflow change on the same edge on which valid rises.
- hex and overflow are register outputs, stable between commits, and free of glitches.
- rst_n asserted in any state: asynchronously return to reset values. An in-progress conversion is discarded and no valid pulse is produced.
- After rst_n deasserts, the first CAPTURE happens on the first rising edge with en=1.

## Test plan
- Reset: hold rst_n=0, then release with en=0. Required: hex = all 7F, overflow=0, valid never pulses.
- Decimal, defaults, en=1, mode=0, blank_lz=0, ch0=37, ch1=5. Required: valid 13 cycles after CAPTURE; ch0 ones=78, tens=30; ch1 ones=12, tens=40; valid repeats every 14 cycles.
- Blanking: blank_lz=1, ch0=0, ch1=5. Required: ch0 ones=40, tens=7F; ch1 ones=12, tens=7F.
- Hex and overflow: instance IN_WIDTH=8, DIGITS=2.
  - mode=1, ch0=0x3F: ones=0E, tens=30, overflow[0]=0.
  - mode=0, ch0=150: both digits 3F, overflow[0]=1.
- Snapshot and enable:
  - Change ch0 from 37 to 12 in the 3rd CONVERT cycle. Required: that commit shows 37; the next commit shows 12.
  - Drop en mid-conversion. Required: one more valid pulse, then outputs hold.
- Reset mid-operation: assert rst_n=0 during CONVERT. Required: hex = all 7F and overflow=0 immediately, no valid pulse. After release, a fresh commit at the normal latency.
